nonce_collector: RTL and testbench
==================================

# nonce_collector

Collects golden nonces from all slaves (local hashcores and external slave_receive ports) and feeds them one at a time to serial_transmit. It sits between the slave result wires (`new_nonces`/`slave_nonces`) and the UART transmitter. It adds per-slave capture, round-robin arbitration and a FIFO, so bursts of simultaneous results are not lost while a 32-bit word is on the wire.

## Interface
Parameters:
- `SLAVES`, 3: number of result sources (LOCAL_MINERS + EXT_PORTS); range 1..16.
- `DEPTH`, 8: FIFO entries; power of two, range 2..64.

Ports:
- `uart_clk`  in  1  single clock for the whole block.
- `reset`  in  1  synchronous, active-low reset.
- `new_nonces`  in  SLAVES  per-slave result strobe; a rising edge means a new nonce.
- `slave_nonces`  in  SLAVES*32  per-slave nonce; slave i occupies bits [i*32+31:i*32] and is valid on the rising edge of `new_nonces[i]`.
- `golden_nonce`  out  32  word presented to serial_transmit; held stable for the whole transmission.
- `serial_send`  out  1  one-cycle pulse that starts transmission.
- `serial_busy`  in  1  transmitter busy.
- `pending`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `dropped`  out  8  saturating count of lost nonces.

## Operation
- Edge detect: register `new_nonces` into `prev`. `edge[i] = new_nonces[i] & ~prev[i]`.
- Capture stage:
  - Per slave, a 32-bit holding register plus a `hold_v` bit.
  - On `edge[i]`, load `slave_nonces[i]` and set `hold_v[i]`.
  - If `hold_v[i]` was already set and is not being drained this cycle, the old value is overwritten and `dropped` increments (saturating at 255).
- Arbiter:
  - Each cycle, if the FIFO is not full or a pop occurs in the same cycle, grant one slave with `hold_v` set, round-robin.
  - Priority starts at the slave after the last granted one; after reset the search starts at slave 0.
  - The granted holding register is written to the FIFO and its `hold_v` clears.
  - A capture into the same slave in the same cycle wins: `hold_v` stays set with the new value, and no drop is counted.
- FIFO:
  - DEPTH x 32, with read/write pointers one bit wider than the address, wrapping modulo 2*DEPTH.
  - Full when the addresses match and the MSBs differ; empty when the pointers are equal.
  - Push and pop in the same cycle leave occupancy unchanged, including when full.
- Transmit FSM:
  - IDLE: if the FIFO is not empty and `serial_busy`=0, pop the head into `golden_nonce` and go to SEND.
  - SEND: assert `serial_send` for one cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: wait for `serial_busy`=1, then go to WAIT_IDLE. If busy is not seen within 4 cycles, go to WAIT_IDLE anyway.
  - WAIT_IDLE: wait for `serial_busy`=0, then go to IDLE.
- Reset values (all outputs 0):
  - `golden_nonce`, `serial_send`, `pending`, `dropped` = 0.
  - `hold_v` = 0, `prev` = 0, FSM = IDLE.
  - Holding and FIFO data are don't-care.
- Reset mid-transmission: the FSM returns to IDLE and queued nonces are discarded. serial_transmit finishes its word independently.

## Timing
- Edge sampled at cycle t → holding register valid at t+1 → FIFO write at t+1 edge (visible at t+2) if granted → FSM pop and `golden_nonce` update at t+2 edge → `serial_send` high during cycle t+3.
- Minimum latency from edge to `serial_send`: 3 cycles.
- `golden_nonce` changes only on an IDLE→SEND transition.
- Throughput: at most one FIFO write per cycle and one transmission per serial_transmit word.
- `new_nonces` held high causes no repeated capture; a level must fall and rise again.

## Structure
- Constants for FSM state encoding live in the shared package/include `hub_defs.v`.
- One sub-module: `nonce_fifo` (parameterised DEPTH, 32-bit, push/pop/full/empty/count).
- Edge detect, holding registers, arbiter and FSM stay in `nonce_collector`.

## Test plan
- Single nonce: slave 1 edge with 32'h0000_1234, busy model asserts 1 cycle after send for 20 cycles → exactly one `serial_send`, `golden_nonce`=32'h0000_1234, `pending` returns to 0, `dropped`=0.
- Simultaneous burst: SLAVES=3, all three edge in the same cycle with 32'hA, 32'hB, 32'hC → transmitted in order A, B, C (round-robin from 0), three sends, each only after busy falls.
- Held level: `new_nonces[0]` held high for 100 cycles → exactly one capture and one send.
- Overflow: DEPTH=2, busy stuck high, then 3 edges on slave 0 at cycles 0/5/10 (or 4 on one slave back-to-back beyond capacity) → FIFO holds 2, the third sits in holding, a fourth overwrite gives `dropped`=1. On busy release, 3 words are sent.
- Busy never asserts: the transmitter model ignores send → FSM leaves WAIT_BUSY after 4 cycles and the next FIFO word is sent.
- Reset mid-operation: 2 words pending, `reset`=0 for 1 cycle → `pending`=0, `serial_send`=0, `dropped`=0, and no further sends until a new edge.

Source files
------------

// File: rtl/nonce_collector_pkg.sv
// Shared types and helpers for the nonce collector.
// Transmit FSM encoding, busy timeout and drop counter arithmetic.
package nonce_collector_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_BUSY,
    WAIT_IDLE
  } tx_state_t;

  // last WAIT_BUSY cycle index before giving up on busy
  localparam logic [1:0] BUSY_TIMEOUT = 2'd3;

  function automatic logic [7:0] sat_add(
    input logic [7:0] a,
    input logic [4:0] b
  );
    logic [8:0] s;
    s = {1'b0, a} + {4'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/nonce_collector_if.sv
// Link between the collector and the serial transmitter.
// The collector drives word and start pulse; the transmitter reports busy.
interface nonce_collector_if;
  import nonce_collector_pkg::*;

  logic [WORD_W-1:0] golden_nonce;
  logic              serial_send;
  logic              serial_busy;

  modport master (
    output golden_nonce,
    output serial_send,
    input  serial_busy
  );

  modport slave (
    input  golden_nonce,
    input  serial_send,
    output serial_busy
  );
endinterface

// File: rtl/nonce_fifo.sv
// 32-bit nonce FIFO with wrap-bit pointers.
// Simultaneous push and pop is legal even when full.
module nonce_fifo
  import nonce_collector_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic do_push;
  logic do_pop;

  assign empty = (wptr == rptr);
  assign full = (wptr[AW-1:0] == rptr[AW-1:0]) &&
                (wptr[AW] != rptr[AW]);
  assign count = wptr - rptr;
  assign dout = mem[rptr[AW-1:0]];

  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/nonce_collector.sv
// Gathers nonces from all slaves and serialises them to the UART.
// Edge capture, round-robin arbiter, FIFO and transmit handshake FSM.
module nonce_collector
  import nonce_collector_pkg::*;
#(
  parameter int SLAVES = 3,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1
) (
  input  logic                     uart_clk,
  input  logic                     reset,
  input  logic [SLAVES-1:0]        new_nonces,
  input  logic [SLAVES*WORD_W-1:0] slave_nonces,
  nonce_collector_if.master        tx,
  output logic [AW:0]              pending,
  output logic [7:0]               dropped
);

  logic [SLAVES-1:0] prev;
  logic [SLAVES-1:0] rise;
  logic [SLAVES-1:0] hold_v;
  logic [SLAVES-1:0] drop;
  logic [WORD_W-1:0] hold [SLAVES];
  logic [SW-1:0] start;
  logic [SW-1:0] gnt;
  logic gnt_v;
  logic [4:0] ndrop;
  int idx;

  logic push;
  logic pop;
  logic full;
  logic empty;
  logic [WORD_W-1:0] head;

  tx_state_t state;
  tx_state_t state_n;
  logic [1:0] wait_cnt;
  logic [WORD_W-1:0] golden_q;
  logic send;
  logic [7:0] drop_cnt;

  assign rise = new_nonces & ~prev;
  assign pop = (state == IDLE) && !empty && !tx.serial_busy;
  assign push = gnt_v;

  always_comb begin
    gnt_v = 1'b0;
    gnt = '0;
    idx = 0;
    if (!full || pop) begin
      for (int k = 0; k < SLAVES; k++) begin
        idx = int'(start) + k;
        if (idx >= SLAVES) idx = idx - SLAVES;
        if (!gnt_v && hold_v[idx]) begin
          gnt_v = 1'b1;
          gnt = SW'(idx);
        end
      end
    end
  end

  // a drain of the same slave this cycle makes room, so no loss
  always_comb begin
    drop = '0;
    ndrop = '0;
    for (int i = 0; i < SLAVES; i++) begin
      drop[i] = rise[i] && hold_v[i] &&
                !(gnt_v && gnt == SW'(i));
      ndrop = ndrop + 5'(drop[i]);
    end
  end

  always_ff @(posedge uart_clk) begin
    if (!reset) begin
      prev <= '0;
      hold_v <= '0;
      start <= '0;
      drop_cnt <= '0;
    end else begin
      prev <= new_nonces;
      drop_cnt <= sat_add(drop_cnt, ndrop);
      if (gnt_v) begin
        hold_v[gnt] <= 1'b0;
        start <= (gnt == SW'(SLAVES - 1)) ? '0 : gnt + 1'b1;
      end
      for (int i = 0; i < SLAVES; i++) begin
        if (rise[i]) hold_v[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge uart_clk) begin
    for (int i = 0; i < SLAVES; i++) begin
      if (rise[i]) hold[i] <= slave_nonces[i*WORD_W +: WORD_W];
    end
  end

  nonce_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk(uart_clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(hold[gnt]),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(pending)
  );

  always_ff @(posedge uart_clk) begin
    if (!reset) begin
      state <= IDLE;
      wait_cnt <= '0;
      golden_q <= '0;
    end else begin
      state <= state_n;
      if (pop) golden_q <= head;
      if (state == WAIT_BUSY) wait_cnt <= wait_cnt + 1'b1;
      else wait_cnt <= '0;
    end
  end

  always_comb begin
    state_n = state;
    send = 1'b0;
    unique case (state)
      IDLE: begin
        if (pop) state_n = SEND;
      end
      SEND: begin
        send = 1'b1;
        state_n = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx.serial_busy || wait_cnt == BUSY_TIMEOUT)
          state_n = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (!tx.serial_busy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign tx.golden_nonce = golden_q;
  assign tx.serial_send = send;
  assign dropped = drop_cnt;

endmodule

// File: tb/tb_nonce_collector.sv
// Directed bench for nonce_collector with a small UART busy model.
// DEPTH=2 so overflow and holding-register behaviour are reachable.
module tb_nonce_collector;
  import nonce_collector_pkg::*;

  localparam int SLAVES = 3;
  localparam int DEPTH = 2;
  localparam int AW = $clog2(DEPTH);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [SLAVES-1:0] new_nonces = '0;
  logic [SLAVES*32-1:0] slave_nonces = '0;
  logic [AW:0] pending;
  logic [7:0] dropped;

  nonce_collector_if bus();

  nonce_collector #(
    .SLAVES(SLAVES),
    .DEPTH(DEPTH)
  ) dut (
    .uart_clk(clk),
    .reset(reset),
    .new_nonces(new_nonces),
    .slave_nonces(slave_nonces),
    .tx(bus),
    .pending(pending),
    .dropped(dropped)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int send_count = 0;
  int early = 0;
  int busy_cnt = 0;
  int busy_len = 20;
  logic ignore = 1'b0;
  logic busy_stuck = 1'b0;
  logic busy_model = 1'b0;
  logic [31:0] sent_q[$];
  int send_cyc[$];

  assign bus.serial_busy = busy_model | busy_stuck;

  always @(posedge clk) cyc++;

  // transmitter model: busy for busy_len cycles after each send
  always @(negedge clk) begin
    logic was_busy;
    was_busy = busy_model | busy_stuck;
    if (busy_cnt > 0) busy_cnt--;
    if (bus.serial_send) begin
      if (was_busy) early++;
      sent_q.push_back(bus.golden_nonce);
      send_cyc.push_back(cyc);
      send_count++;
      if (!ignore) busy_cnt = busy_len;
    end
    busy_model = (busy_cnt > 0);
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sent_at(int i);
    if (i < sent_q.size()) return sent_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic pulse(int s, logic [31:0] v);
    @(posedge clk); #1;
    slave_nonces[s*32 +: 32] = v;
    new_nonces[s] = 1'b1;
    @(posedge clk); #1;
    new_nonces[s] = 1'b0;
  endtask

  task automatic wait_sends(int target, int budget);
    int n;
    n = 0;
    while (send_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (30) @(negedge clk);
    chk("send_count", send_count, target);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    int base;
    int lat;
    logic found;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pending", pending, 0);
    chk("rst_send", bus.serial_send, 0);
    chk("rst_golden", bus.golden_nonce, 0);
    chk("rst_dropped", dropped, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // single nonce, latency edge -> send
    base = send_count;
    @(posedge clk); #1;
    slave_nonces[63:32] = 32'h0000_1234;
    new_nonces[1] = 1'b1;
    lat = 0;
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      @(negedge clk);
      if (bus.serial_send) found = 1'b1;
      else lat++;
    end
    new_nonces[1] = 1'b0;
    chk("latency", lat, 3);
    wait_sends(base + 1, 100);
    chk("single_val", sent_at(base), 32'h0000_1234);
    chk("single_pend", pending, 0);
    chk("single_drop", dropped, 0);

    // simultaneous burst, round robin restarts at slave 0
    do_reset();
    base = send_count;
    @(posedge clk); #1;
    slave_nonces = {32'hC, 32'hB, 32'hA};
    new_nonces = 3'b111;
    @(posedge clk); #1;
    new_nonces = 3'b000;
    wait_sends(base + 3, 300);
    chk("burst_0", sent_at(base), 32'hA);
    chk("burst_1", sent_at(base + 1), 32'hB);
    chk("burst_2", sent_at(base + 2), 32'hC);
    chk("send_vs_busy", early, 0);

    // level held high captures once
    base = send_count;
    @(posedge clk); #1;
    slave_nonces[31:0] = 32'h55;
    new_nonces[0] = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    new_nonces[0] = 1'b0;
    wait_sends(base + 1, 50);
    chk("held_val", sent_at(base), 32'h55);

    // overflow: FIFO 2 deep, holding register, then overwrite
    base = send_count;
    busy_stuck = 1'b1;
    pulse(0, 32'h1);
    repeat (3) @(posedge clk);
    pulse(0, 32'h2);
    repeat (3) @(posedge clk);
    pulse(0, 32'h3);
    repeat (3) @(posedge clk);
    pulse(0, 32'h4);
    repeat (3) @(negedge clk);
    chk("ovf_pend", pending, 2);
    chk("ovf_drop", dropped, 1);
    chk("ovf_nosend", send_count, base);
    @(posedge clk); #1;
    busy_stuck = 1'b0;
    wait_sends(base + 3, 300);
    chk("ovf_0", sent_at(base), 32'h1);
    chk("ovf_1", sent_at(base + 1), 32'h2);
    chk("ovf_2", sent_at(base + 2), 32'h4);

    // transmitter never raises busy: timeout path
    base = send_count;
    ignore = 1'b1;
    pulse(2, 32'hD0);
    pulse(2, 32'hD1);
    wait_sends(base + 2, 100);
    chk("nobusy_0", sent_at(base), 32'hD0);
    chk("nobusy_1", sent_at(base + 1), 32'hD1);
    if (send_cyc.size() >= base + 2)
      chk("nobusy_gap", send_cyc[base + 1] - send_cyc[base], 7);
    else
      chk("nobusy_gap", 0, 7);
    ignore = 1'b0;

    // reset with words queued
    busy_stuck = 1'b1;
    pulse(0, 32'h77);
    pulse(0, 32'h78);
    repeat (3) @(negedge clk);
    chk("mid_pend", pending, 2);
    base = send_count;
    do_reset();
    @(negedge clk);
    chk("mid_rst_pend", pending, 0);
    chk("mid_rst_send", bus.serial_send, 0);
    chk("mid_rst_drop", dropped, 0);
    @(posedge clk); #1;
    busy_stuck = 1'b0;
    repeat (50) @(negedge clk);
    chk("mid_no_send", send_count, base);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
